// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared mesh_xy_noc packet-format helpers. A packet is
//                {row address, column address, payload}, MSB first. The
//                functions here give the total packet width and the offset
//                and width of every field so that packers and unpackers agree.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  // Width of the row address field for a mesh with row_n rows.
  function automatic int row_w(input int row_n);
    return $clog2(row_n);
  endfunction

  // Width of the column address field for a mesh with col_m columns.
  function automatic int col_w(input int col_m);
    return $clog2(col_m);
  endfunction

  // Payload occupies the least significant bits of the packet.
  function automatic int data_off();
    return 0;
  endfunction

  // Column field sits directly above the payload.
  function automatic int col_off(input int data_w);
    return data_w;
  endfunction

  // Row field sits directly above the column field.
  function automatic int row_off(input int col_m, input int data_w);
    return data_w + col_w(col_m);
  endfunction

  // Total packet width: row + column + payload.
  function automatic int packet_w(input int row_n, input int col_m, input int data_w);
    return row_w(row_n) + col_w(col_m) + data_w;
  endfunction

endpackage : noc_pkg
`default_nettype wire

// File: rtl/rsc_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rsc_rx_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head entry is
//                presented combinationally whenever the FIFO is non-empty.
//                Full is decoded from the registered count only, so a pop in
//                the same cycle never lets a write through a full FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsc_rx_fifo #(
  parameter int DEPTH_W = 3,
  parameter int DATA_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_accept
);

  localparam int DEPTH = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0] c_depth = (DEPTH_W + 1)'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W-1:0] r_rd_ptr;
  logic [DEPTH_W:0]   r_count;

  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_depth);
  assign w_valid = (r_count != '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & w_valid;

  assign o_full   = w_full;
  assign o_valid  = w_valid;
  assign o_accept = w_push;
  assign o_data   = w_valid ? r_mem[r_rd_ptr] : '0;

  // Storage array; contents are don't-care after reset because the count is cleared.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : rsc_rx_fifo
`default_nettype wire

// File: rtl/rsc_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : rsc_rx_if
//  Description : Resource-side receive interface of a mesh_xy_noc node.
//                Buffers packets from the router's resource output in a FIFO,
//                signals back-pressure via full_o, pulses ovrflw_o for every
//                dropped packet and counts stored packets in rx_cnt_o.
//                Optional build macro RSC_RX_ADDR_CHECK_EN enables checking of
//                the destination address against ROW_IDX/COL_IDX; mismatching
//                packets are discarded and flagged on the sticky misroute_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsc_rx_if
  import noc_pkg::*;
#(
  parameter int ROW_N        = 3,
  parameter int COL_M        = 3,
  parameter int FIFO_DEPTH_W = 3,
  parameter int PCKT_DATA_W  = 8,
  parameter int ROW_IDX      = 0,
  parameter int COL_IDX      = 0,
  parameter int CNT_W        = 16
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [packet_w(ROW_N, COL_M, PCKT_DATA_W)-1:0]   pckt_i,
  input  logic                                             wren_i,
  output logic                                             full_o,
  output logic                                             ovrflw_o,
  output logic [PCKT_DATA_W-1:0]                           data_o,
  output logic                                             valid_o,
  input  logic                                             ready_i,
  output logic                                             misroute_o,
  output logic [CNT_W-1:0]                                 rx_cnt_o
);

  localparam int ROW_W   = row_w(ROW_N);
  localparam int COL_W   = col_w(COL_M);
  localparam int ROW_OFF = row_off(COL_M, PCKT_DATA_W);
  localparam int COL_OFF = col_off(PCKT_DATA_W);
  localparam int DAT_OFF = data_off();

  localparam logic [ROW_W-1:0] c_row_idx = ROW_W'(ROW_IDX);
  localparam logic [COL_W-1:0] c_col_idx = COL_W'(COL_IDX);

  // Packet field split.
  logic [ROW_W-1:0]       w_row;
  logic [COL_W-1:0]       w_col;
  logic [PCKT_DATA_W-1:0] w_payload;

  assign w_row     = pckt_i[ROW_OFF +: ROW_W];
  assign w_col     = pckt_i[COL_OFF +: COL_W];
  assign w_payload = pckt_i[DAT_OFF +: PCKT_DATA_W];

  logic w_addr_ok;
  logic w_full;
  logic w_accept;

`ifdef RSC_RX_ADDR_CHECK_EN
  logic r_misroute;
  logic w_mis_set;

  assign w_addr_ok = (w_row == c_row_idx) && (w_col == c_col_idx);
  assign w_mis_set = wren_i & ~w_addr_ok;

  // Sticky misroute flag: set by any foreign-destination write, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_misroute <= 1'b0;
    end else if (w_mis_set) begin
      r_misroute <= 1'b1;
    end
  end

  assign misroute_o = r_misroute;
`else
  logic w_unused_addr;

  // Address fields are carried but never inspected in this build.
  assign w_addr_ok     = 1'b1;
  assign w_unused_addr = ^{w_row, w_col, c_row_idx, c_col_idx};
  assign misroute_o    = 1'b0;
`endif

  rsc_rx_fifo #(
    .DEPTH_W (FIFO_DEPTH_W),
    .DATA_W  (PCKT_DATA_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_push   (wren_i & w_addr_ok),
    .i_data   (w_payload),
    .i_pop    (ready_i),
    .o_data   (data_o),
    .o_valid  (valid_o),
    .o_full   (w_full),
    .o_accept (w_accept)
  );

  assign full_o = w_full;

  logic             r_ovrflw;
  logic [CNT_W-1:0] r_rx_cnt;

  // One-cycle drop pulse per write attempted against a full buffer; repeats back to back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovrflw <= 1'b0;
    end else begin
      r_ovrflw <= wren_i & w_full;
    end
  end

  // Count of packets actually stored; wraps naturally at 2**CNT_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_cnt <= '0;
    end else if (w_accept) begin
      r_rx_cnt <= r_rx_cnt + 1'b1;
    end
  end

  assign ovrflw_o = r_ovrflw;
  assign rx_cnt_o = r_rx_cnt;

endmodule : rsc_rx_if
`default_nettype wire

// File: tb/tb_rsc_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsc_rx_if
//  Description : Self-checking bench for rsc_rx_if. ROW_N=COL_M=3, node (1,2),
//                depth 8, 8-bit payload, 4-bit packet counter. Expected
//                values come from a queue-based reference model and from
//                literal values for the directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rsc_rx_if;

  localparam int ROW_N = 3;
  localparam int COL_M = 3;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int PW    = 12;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [PW-1:0] pckt_i;
  logic          wren_i;
  logic          full_o;
  logic          ovrflw_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          misroute_o;
  logic [CW-1:0] rx_cnt_o;

  int errors = 0;
  int checks = 0;

  rsc_rx_if #(
    .ROW_N        (ROW_N),
    .COL_M        (COL_M),
    .FIFO_DEPTH_W (3),
    .PCKT_DATA_W  (DW),
    .ROW_IDX      (1),
    .COL_IDX      (2),
    .CNT_W        (CW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pckt_i     (pckt_i),
    .wren_i     (wren_i),
    .full_o     (full_o),
    .ovrflw_o   (ovrflw_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .misroute_o (misroute_o),
    .rx_cnt_o   (rx_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_q[$];
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;
  logic          m_mis = 1'b0;

  function automatic logic addr_ok(input logic [PW-1:0] p);
`ifdef RSC_RX_ADDR_CHECK_EN
    return (p[11:10] == 2'd1) && (p[9:8] == 2'd2);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_update(input logic r, input logic w, input logic [PW-1:0] p, input logic rd);
    bit was_full;
    bit do_pop;
    if (r) begin
      m_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_mis = 1'b0;
    end else begin
      was_full = (m_q.size() == 8);
      do_pop   = rd && (m_q.size() != 0);
      m_ovf    = w && was_full;
      if (w && !addr_ok(p)) m_mis = 1'b1;
      if (do_pop) void'(m_q.pop_front());
      if (w && addr_ok(p) && !was_full) begin
        m_q.push_back(p[7:0]);
        m_cnt = (m_cnt + 1) % 16;
      end
    end
  endtask

  function automatic logic [15:0] model_out();
    logic [DW-1:0] d;
    d = (m_q.size() != 0) ? m_q[0] : 8'h00;
    return {(m_q.size() == 8), m_ovf, (m_q.size() != 0), m_mis, 4'(m_cnt), d};
  endfunction

  function automatic logic [15:0] dut_out();
    return {full_o, ovrflw_o, valid_o, misroute_o, rx_cnt_o, data_o};
  endfunction

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic w, input logic [PW-1:0] p, input logic rd);
    rst_i  = r;
    wren_i = w;
    pckt_i = p;
    ready_i = rd;
    model_update(r, w, p, rd);
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (dut_out() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: got %h expected 0000", dut_out());
    end
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_single();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 12'h6A5, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 8'hA5 || rx_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL single_write: got v=%b d=%h cnt=%0d expected v=1 d=a5 cnt=1", valid_o, data_o, rx_cnt_o);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00) begin
      errors++;
      $display("FAIL single_pop: got v=%b d=%h expected v=0 d=00", valid_o, data_o);
    end
  endtask

  task automatic test_fill_overflow();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 12'h600 | 12'(i), 1'b0);
      if (i == 6 || i == 7) begin
        checks++;
        if (full_o !== (i == 7) || ovrflw_o !== 1'b0) begin
          errors++;
          $display("FAIL fill_full_%0d: got full=%b ovf=%b expected full=%b ovf=0", i, full_o, ovrflw_o, (i == 7));
        end
      end
    end
    checks++;
    if (ovrflw_o !== 1'b1 || full_o !== 1'b1 || rx_cnt_o !== 4'd8) begin
      errors++;
      $display("FAIL drop_pulse: got ovf=%b full=%b cnt=%0d expected ovf=1 full=1 cnt=8", ovrflw_o, full_o, rx_cnt_o);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (ovrflw_o !== 1'b0 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse_end: got ovf=%b full=%b expected ovf=0 full=1", ovrflw_o, full_o);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (valid_o !== 1'b1 || data_o !== 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d: got v=%b d=%h expected v=1 d=%h", i, valid_o, data_o, 8'(i));
      end
      step(1'b0, 1'b0, '0, 1'b1);
      if (i == 0) begin
        checks++;
        if (full_o !== 1'b0) begin
          errors++;
          $display("FAIL full_fall: got %b expected 0", full_o);
        end
      end
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got v=%b expected 0", valid_o);
    end
  endtask

  task automatic test_push_pop();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 12'h610 + 12'(k), 1'b0);
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 1'b1, 12'h614 + 12'(j), 1'b1);
      checks++;
      if (full_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'(8'h11 + j)) begin
        errors++;
        $display("FAIL push_pop_%0d: got full=%b v=%b d=%h expected full=0 v=1 d=%h", j, full_o, valid_o, data_o, 8'(8'h11 + j));
      end
    end
    // Four entries must remain: drain them and confirm emptiness afterwards.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_count: got v=%b expected 0 after 4 pops", valid_o);
    end
  endtask

  task automatic test_misroute();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 12'h2A5, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
`ifdef RSC_RX_ADDR_CHECK_EN
    if (valid_o !== 1'b0 || misroute_o !== 1'b1 || rx_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL misroute: got v=%b mis=%b cnt=%0d expected v=0 mis=1 cnt=0", valid_o, misroute_o, rx_cnt_o);
    end
`else
    if (valid_o !== 1'b1 || data_o !== 8'hA5 || misroute_o !== 1'b0 || rx_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL misroute: got v=%b d=%h mis=%b cnt=%0d expected v=1 d=a5 mis=0 cnt=1", valid_o, data_o, misroute_o, rx_cnt_o);
    end
`endif
    step(1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (misroute_o !== 1'b0) begin
      errors++;
      $display("FAIL misroute_clear: got %b expected 0", misroute_o);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 12'h6C0 + 12'(k), 1'b0);
    step(1'b1, 1'b1, 12'h6EE, 1'b0);
    checks++;
    if (dut_out() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0000", dut_out());
    end
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (valid_o !== 1'b0 || rx_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_write_ignored: got v=%b cnt=%0d expected v=0 cnt=0", valid_o, rx_cnt_o);
    end
  endtask

  task automatic test_cnt_wrap();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 17; k++) step(1'b0, 1'b1, 12'h6A5, 1'b1);
    checks++;
    if (rx_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d expected 1", rx_cnt_o);
    end
  endtask

  task automatic test_random();
    logic          r;
    logic          w;
    logic          rd;
    logic [PW-1:0] p;
    int            rd_pct;
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      rd_pct = ((i / 60) % 2 == 0) ? 25 : 75;
      r  = ($urandom_range(0, 79) == 0);
      w  = ($urandom_range(0, 99) < 70);
      rd = ($urandom_range(0, 99) < rd_pct);
      if ($urandom_range(0, 99) < 80) p = {2'd1, 2'd2, 8'($urandom)};
      else                            p = 12'($urandom);
      step(r, w, p, rd);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL random_%0d: got {full,ovf,v,mis,cnt,d}=%h expected %h", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    wren_i  = 1'b0;
    pckt_i  = '0;
    ready_i = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_push_pop();
    test_misroute();
    test_reset_mid();
    test_cnt_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rsc_rx_if
`default_nettype wire

// File: doc/rsc_rx_if.md
# rsc_rx_if

Resource-side receive interface for one mesh_xy_noc node: it terminates the router's resource output channel (packet, wren, full, ovrflw) and presents the payload to the local resource through a valid/ready handshake. Arriving packets are buffered in a FIFO and back-pressure is signalled to the router through full. Optionally, the destination address is checked against the node's own coordinates.

## Interface
- ROW_N, 3, mesh rows
- COL_M, 3, mesh columns
- FIFO_DEPTH_W, 3, log2 of buffer depth (depth = 2**FIFO_DEPTH_W)
- PCKT_DATA_W, 8, payload width
- ROW_IDX, 0, row coordinate of this node
- COL_IDX, 0, column coordinate of this node
- CNT_W, 16, width of the accepted-packet counter
- clk_i  input  1  clock, all logic rising-edge
- rst_i  input  1  synchronous, active-high reset
- pckt_i  input  PACKET_W  packet from router; PACKET_W = PCKT_DATA_W + $clog2(ROW_N) + $clog2(COL_M)
- wren_i  input  1  packet strobe, one packet per cycle high
- full_o  output  1  buffer cannot accept a packet this cycle
- ovrflw_o  output  1  one-cycle pulse: a packet was dropped because the buffer was full
- data_o  output  PCKT_DATA_W  head-of-buffer payload
- valid_o  output  1  data_o holds a valid payload
- ready_i  input  1  consumer accepts data_o when valid_o is high
- misroute_o  output  1  sticky; a packet with a foreign destination was received
- rx_cnt_o  output  CNT_W  number of packets stored since reset; wraps

## Operation
- Packet layout, MSB first: {row address, column address, payload}.
  - Row address: $clog2(ROW_N) bits. Column address: $clog2(COL_M) bits. Payload: PCKT_DATA_W bits.
- Write: when wren_i is high and full_o is low, the payload is written at the write pointer, and the write pointer, occupancy count and rx_cnt_o all increment.
- Drop on full: when wren_i is high and full_o is high, the packet is discarded and ovrflw_o pulses on the next cycle. No other state changes.
- full_o = (count == 2**FIFO_DEPTH_W).
  - Decoded from registered state only; there is no combinational path from wren_i.
  - A simultaneous pop does not unblock a write in the same cycle (no bypass).
- Read: valid_o = (count != 0), and data_o = mem[rd_ptr].
  - A pop occurs when valid_o and ready_i are both high.
  - data_o is 0 while valid_o is low.
- Simultaneous push and pop with count between 1 and depth-1: both pointers advance and the count is unchanged.
- Pointers are FIFO_DEPTH_W bits wide and wrap naturally.
- The count is FIFO_DEPTH_W+1 bits wide.
- rx_cnt_o wraps from 2**CNT_W-1 to 0.
- Reset (including mid-operation): pointers, count, rx_cnt_o, misroute_o and ovrflw_o are cleared. Buffered packets are lost; memory contents need not be cleared.
- wren_i asserted in the same cycle as rst_i is ignored.

## Timing
- Reset values: full_o=0, ovrflw_o=0, valid_o=0, data_o=0, misroute_o=0, rx_cnt_o=0.
- Write to read latency: a packet written in cycle N is visible on valid_o/data_o in cycle N+1.
- full_o rises in the cycle after the write that fills the buffer.
- full_o falls in the cycle after the first pop from a full buffer.
- ovrflw_o is high for exactly one cycle per dropped packet. Back-to-back drops keep it high continuously.
- misroute_o sets in the cycle after the offending write and holds until reset.

## Configuration
- RSC_RX_ADDR_CHECK_EN defined:
  - The packet's row/column fields are compared with ROW_IDX/COL_IDX on every wren_i.
  - A mismatching packet is not stored, does not increment rx_cnt_o, and sets misroute_o.
  - A mismatch that arrives while the buffer is full sets misroute_o and also pulses ovrflw_o.
- RSC_RX_ADDR_CHECK_EN undefined:
  - No comparison is made; every packet is handled by the full/drop rules only.
  - misroute_o is tied to 0.

## Structure
- Shared package noc_pkg holds:
  - PACKET_W, computed by a function of ROW_N, COL_M and PCKT_DATA_W;
  - field offset/width functions for the row, column and payload fields.
  - The mesh_xy_noc packing also uses these.
- Sub-module rsc_rx_fifo: synchronous first-word-fall-through FIFO (memory, pointers, count, full/empty).
- rsc_rx_if adds the address check, the ovrflw_o pulse, misroute_o and rx_cnt_o.

## Test plan
All scenarios use ROW_N=COL_M=3, ROW_IDX=1, COL_IDX=2, depth 8, so a local packet is 0x6A5 (payload 0xA5).
- Single packet: wren_i one cycle with 0x6A5 and ready_i=0 -> next cycle valid_o=1, data_o=0xA5, rx_cnt_o=1; pulse ready_i -> valid_o=0, data_o=0.
- Fill and overflow: 9 consecutive writes 0x600..0x608 with ready_i=0 -> full_o=1 after the 8th; the 9th is dropped and ovrflw_o is high one cycle; draining yields payloads 0x00..0x07 in order.
- Simultaneous push/pop at count=4 for 20 cycles -> count stays 4, full_o=0 throughout, output order preserved across pointer wrap.
- Misroute with RSC_RX_ADDR_CHECK_EN: write 0x2A5 (row 0, column 2) -> not stored, valid_o stays 0, misroute_o=1 until reset, rx_cnt_o unchanged. Without the macro: 0x2A5 is stored and misroute_o=0.
- Reset mid-operation: rst_i asserted with 5 packets buffered and wren_i high -> next cycle all outputs at reset values; the write in the reset cycle is not stored.
- Counter wrap: CNT_W=4, 17 accepted packets -> rx_cnt_o reads 1.
